// File: rtl/mem_grant_scheduler.sv
// mem_grant_scheduler: arbitrates one shared memory resource between three
// masters. M1 has absolute priority and may preempt M2/M3. M2 and M3 share
// a round-robin pointer and are limited to MAX_HOLD consecutive grant cycles.
// The block also counts preemptions and flags requesters that starve.
module mem_grant_scheduler #(
  parameter int MAX_HOLD   = 2,
  parameter int STARVE_LIM = 6,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [2:0]       done,
  output logic [2:0]       gnt,
  output logic [1:0]       owner,
  output logic             preempt,
  output logic [CNT_W-1:0] nb_preempts,
  output logic             starve_err
);

  localparam int HOLD_W = (MAX_HOLD   > 1) ? $clog2(MAX_HOLD + 1)   : 1;
  localparam int WAIT_W = (STARVE_LIM > 1) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIM);
  localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};

  // The state encoding doubles as the owner code, so owner is the state itself.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN1 = 2'b01,
    ST_OWN2 = 2'b10,
    ST_OWN3 = 2'b11
  } state_t;

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_rr;        // 0: favour M2 on contention, 1: favour M3
  logic                r_preempt;
  logic [CNT_W-1:0]    r_nb_preempts;
  logic [WAIT_W-1:0]   r_wait2;
  logic [WAIT_W-1:0]   r_wait3;
  logic                r_starve;

  logic                w_own_req;
  logic                w_own_done;
  logic                w_is_m23;
  logic                w_free;
  logic                w_preempt;
  state_t              w_arb_state;
  logic                w_arb_toggle;
  logic [WAIT_W-1:0]   w_wait2_nxt;
  logic [WAIT_W-1:0]   w_wait3_nxt;

  // Select the current owner's own req/done bits; non-owner done bits are ignored.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_done = 1'b0;
    w_is_m23   = 1'b0;
    case (r_state)
      ST_OWN1: begin
        w_own_req  = req[0];
        w_own_done = done[0];
      end
      ST_OWN2: begin
        w_own_req  = req[1];
        w_own_done = done[1];
        w_is_m23   = 1'b1;
      end
      ST_OWN3: begin
        w_own_req  = req[2];
        w_own_done = done[2];
        w_is_m23   = 1'b1;
      end
      default: begin
        w_own_req  = 1'b0;
        w_own_done = 1'b0;
        w_is_m23   = 1'b0;
      end
    endcase
  end

  // Resource is free when idle, released, abandoned, or an M2/M3 hold expired.
  always_comb begin
    w_free    = (r_state == ST_IDLE) || w_own_done || !w_own_req ||
                (w_is_m23 && (r_hold >= HOLD_MAX));
    w_preempt = !w_free && w_is_m23 && req[0];
  end

  // Winner of a free-resource arbitration: M1 first, then M2/M3 by round robin.
  always_comb begin
    w_arb_state  = ST_IDLE;
    w_arb_toggle = 1'b0;
    if (req[0]) begin
      w_arb_state = ST_OWN1;
    end else if (req[1] && req[2]) begin
      w_arb_state  = r_rr ? ST_OWN3 : ST_OWN2;
      w_arb_toggle = 1'b1;
    end else if (req[1]) begin
      w_arb_state = ST_OWN2;
    end else if (req[2]) begin
      w_arb_state = ST_OWN3;
    end else begin
      w_arb_state = ST_IDLE;
    end
  end

  // Grant vector decoded from the registered state.
  always_comb begin
    case (r_state)
      ST_OWN1: gnt = 3'b001;
      ST_OWN2: gnt = 3'b010;
      ST_OWN3: gnt = 3'b100;
      default: gnt = 3'b000;
    endcase
  end

  // Next wait-counter values: count while requesting and not granted, else clear.
  always_comb begin
    if (req[1] && !gnt[1]) begin
      w_wait2_nxt = (r_wait2 == WAIT_MAX) ? r_wait2 : r_wait2 + WAIT_W'(1);
    end else begin
      w_wait2_nxt = '0;
    end
    if (req[2] && !gnt[2]) begin
      w_wait3_nxt = (r_wait3 == WAIT_MAX) ? r_wait3 : r_wait3 + WAIT_W'(1);
    end else begin
      w_wait3_nxt = '0;
    end
  end

  // Ownership FSM: arbitration, preemption, hold counting and preemption stats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_hold        <= '0;
      r_rr          <= 1'b0;
      r_preempt     <= 1'b0;
      r_nb_preempts <= '0;
    end else if (w_free) begin
      r_state   <= w_arb_state;
      r_hold    <= (w_arb_state == ST_IDLE) ? HOLD_W'(0) : HOLD_W'(1);
      r_preempt <= 1'b0;
      if (w_arb_toggle) begin
        r_rr <= ~r_rr;
      end else begin
        r_rr <= r_rr;
      end
    end else if (w_preempt) begin
      // Preempted owner keeps no credit; it simply re-arbitrates later.
      r_state   <= ST_OWN1;
      r_hold    <= HOLD_W'(1);
      r_preempt <= 1'b1;
      if (r_nb_preempts != CNT_SAT) begin
        r_nb_preempts <= r_nb_preempts + CNT_W'(1);
      end
    end else begin
      // Same owner keeps the resource; M1 may hold indefinitely, so saturate.
      r_state   <= r_state;
      r_preempt <= 1'b0;
      if (r_hold != HOLD_MAX) begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end
  end

  // Starvation monitor: per-requester wait counters and the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait2  <= '0;
      r_wait3  <= '0;
      r_starve <= 1'b0;
    end else begin
      r_wait2  <= w_wait2_nxt;
      r_wait3  <= w_wait3_nxt;
      r_starve <= r_starve || (w_wait2_nxt == WAIT_MAX) || (w_wait3_nxt == WAIT_MAX);
    end
  end

  assign owner       = r_state;
  assign preempt     = r_preempt;
  assign nb_preempts = r_nb_preempts;
  assign starve_err  = r_starve;

endmodule

// File: tb/tb_mem_grant_scheduler.sv
// Directed bench for mem_grant_scheduler: a vector table walked edge by edge,
// followed by hand-written sequences for long holds, starvation and reset.
module tb_mem_grant_scheduler;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req;
  logic [2:0]  done;
  logic [2:0]  gnt;
  logic [1:0]  owner;
  logic        preempt;
  logic [15:0] nb_preempts;
  logic        starve_err;
  logic [2:0]  gnt_s;
  logic [1:0]  owner_s;
  logic        preempt_s;
  logic [1:0]  nb_preempts_s;
  logic        starve_err_s;

  int n_checks;
  int n_fail;

  mem_grant_scheduler dut (
    .clk(clk), .reset(reset_n), .req(req), .done(done),
    .gnt(gnt), .owner(owner), .preempt(preempt),
    .nb_preempts(nb_preempts), .starve_err(starve_err)
  );

  mem_grant_scheduler #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset_n), .req(req), .done(done),
    .gnt(gnt_s), .owner(owner_s), .preempt(preempt_s),
    .nb_preempts(nb_preempts_s), .starve_err(starve_err_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] gnt;
    logic       pre;
    int         cnt;
  } vec_t;

  vec_t tbl[25];

  function automatic logic [1:0] owner_of(input logic [2:0] g);
    case (g)
      3'b001:  return 2'b01;
      3'b010:  return 2'b10;
      3'b100:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs, take one rising edge, then settle away from the edge.
  task automatic step(input logic [2:0] r, input logic [2:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 3'b000;
    done    = 3'b000;
    @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_preempt", 32'(preempt), 32'h0);
    chk("rst_cnt", 32'(nb_preempts), 32'h0);
    chk("rst_starve", 32'(starve_err), 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            req     done    gnt    pre   cnt
    tbl[0]  = '{3'b110, 3'b000, 3'b010, 1'b0, 0}; // contention: M2 first
    tbl[1]  = '{3'b110, 3'b000, 3'b010, 1'b0, 0};
    tbl[2]  = '{3'b110, 3'b000, 3'b100, 1'b0, 0}; // hold expired, M3 turn
    tbl[3]  = '{3'b110, 3'b000, 3'b100, 1'b0, 0};
    tbl[4]  = '{3'b110, 3'b000, 3'b010, 1'b0, 0};
    tbl[5]  = '{3'b110, 3'b000, 3'b010, 1'b0, 0};
    tbl[6]  = '{3'b000, 3'b000, 3'b000, 1'b0, 0}; // idle
    tbl[7]  = '{3'b010, 3'b000, 3'b010, 1'b0, 0};
    tbl[8]  = '{3'b011, 3'b000, 3'b001, 1'b1, 1}; // preempt M2
    tbl[9]  = '{3'b011, 3'b000, 3'b001, 1'b0, 1};
    tbl[10] = '{3'b011, 3'b110, 3'b001, 1'b0, 1}; // non-owner done ignored
    tbl[11] = '{3'b010, 3'b000, 3'b010, 1'b0, 1}; // M1 drops req
    tbl[12] = '{3'b101, 3'b010, 3'b001, 1'b0, 1}; // done + req0: no preempt
    tbl[13] = '{3'b100, 3'b001, 3'b100, 1'b0, 1}; // release, no bubble
    tbl[14] = '{3'b101, 3'b000, 3'b001, 1'b1, 2}; // preempt M3
    tbl[15] = '{3'b100, 3'b000, 3'b100, 1'b0, 2};
    tbl[16] = '{3'b100, 3'b000, 3'b100, 1'b0, 2};
    tbl[17] = '{3'b100, 3'b000, 3'b100, 1'b0, 2}; // forced release, re-granted
    tbl[18] = '{3'b101, 3'b000, 3'b001, 1'b1, 3};
    tbl[19] = '{3'b000, 3'b000, 3'b000, 1'b0, 3};
    tbl[20] = '{3'b010, 3'b000, 3'b010, 1'b0, 3};
    tbl[21] = '{3'b011, 3'b000, 3'b001, 1'b1, 4};
    tbl[22] = '{3'b010, 3'b000, 3'b010, 1'b0, 4};
    tbl[23] = '{3'b011, 3'b000, 3'b001, 1'b1, 5};
    tbl[24] = '{3'b000, 3'b000, 3'b000, 1'b0, 5};

    reset_n = 1'b0;
    req     = 3'b000;
    done    = 3'b000;
    #2;
    do_reset();

    // Table walk from IDLE right after reset.
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].req, tbl[i].done);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(owner_of(tbl[i].gnt)));
      chk($sformatf("tbl%0d_preempt", i), 32'(preempt), 32'(tbl[i].pre));
      chk($sformatf("tbl%0d_cnt", i), 32'(nb_preempts), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_cnt_sat", i), 32'(nb_preempts_s),
          32'((tbl[i].cnt > 3) ? 3 : tbl[i].cnt));
    end
    chk("tbl_no_starve", 32'(starve_err), 32'h0);

    // M1 holds with no limit, then hands straight to M3.
    for (int i = 0; i < 10; i++) begin
      step(3'b001, 3'b000);
      chk($sformatf("m1hold%0d_gnt", i), 32'(gnt), 32'h1);
    end
    step(3'b100, 3'b001);
    chk("m1_to_m3_gnt", 32'(gnt), 32'h4);
    chk("m1_to_m3_owner", 32'(owner), 32'h3);

    // Starvation: M2 waits behind M1; flag rises on the 6th wait cycle.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(3'b011, 3'b000);
      chk($sformatf("starve_gnt%0d", i), 32'(gnt), 32'h1);
      chk($sformatf("starve_flag%0d", i), 32'(starve_err), (i >= 6) ? 32'h1 : 32'h0);
    end
    step(3'b010, 3'b000);
    chk("starve_m2_gnt", 32'(gnt), 32'h2);
    chk("starve_sticky", 32'(starve_err), 32'h1);

    // Reset asserted mid-OWN3 drops the grant without a clock edge.
    step(3'b100, 3'b000);
    chk("pre_rst_gnt", 32'(gnt), 32'h4);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_owner", 32'(owner), 32'h0);
    chk("async_rst_starve", 32'(starve_err), 32'h0);
    req = 3'b110;
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h2);
    chk("post_rst_owner", 32'(owner), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_grant_scheduler.md
MEM_GRANT_SCHEDULER -- requirements
Module: mem_grant_scheduler

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 2, the maximum number of consecutive grant cycles for M2 or M3.
REQ-002 SHALL have parameter STARVE_LIM, default 6, the wait-cycle count at which starvation is flagged.
REQ-003 SHALL have parameter CNT_W, default 16, the width of the preemption counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, 3 bits: requests; bit0 = M1, bit1 = M2, bit2 = M3.
REQ-007 SHALL have port done, input, 3 bits: release indications, same bit mapping as req.
REQ-008 SHALL have port gnt, output, 3 bits: registered grant, one-hot or zero.
REQ-009 SHALL have port owner, output, 2 bits: 00 none, 01 M1, 10 M2, 11 M3; always consistent with gnt.
REQ-010 SHALL have port preempt, output, 1 bit: one-cycle pulse marking the first M1 grant cycle after a preemption.
REQ-011 SHALL have port nb_preempts, output, CNT_W bits: count of preemptions, saturating.
REQ-012 SHALL have port starve_err, output, 1 bit: sticky starvation flag.

Function
REQ-013 SHALL implement states IDLE, OWN1, OWN2, OWN3, one owner at most; gnt and owner are decoded from the registered state.
REQ-014 SHALL arbitrate in any cycle where the resource is free, and the winner's gnt SHALL assert on the next rising edge.
REQ-015 SHALL treat the resource as free when any of these holds: state IDLE; owner's done bit high; owner's req bit low; M2/M3 hold counter equal to MAX_HOLD.
REQ-016 SHALL apply fixed priority when free: M1 wins whenever req[0]=1.
REQ-017 SHALL grant the sole requester when only one of M2/M3 requests (and M1 does not).
REQ-018 SHALL resolve contention between M2 and M3 with a 1-bit round-robin pointer; the pointer favours M2 after reset and toggles to the other requester after each contended grant.
REQ-019 SHALL go to IDLE with gnt=000 when free and req=000.
REQ-020 SHALL re-arbitrate in the same cycle on release, with no idle bubble: done plus a pending req moves straight to the next owner.
REQ-021 SHALL keep a hold counter that is 1 in the owner's first grant cycle and increments each cycle the same owner is held.
REQ-022 SHALL force release of M2/M3 after MAX_HOLD cycles, even if done is low.
REQ-023 SHALL give M1 unlimited hold, released only by done[0] or req[0] low.
REQ-024 SHALL preempt when owner is M2 or M3, hold counter < MAX_HOLD, owner's done is low, and req[0]=1: next state OWN1.
REQ-025 On preemption, preempt SHALL be 1 during that first OWN1 cycle.
REQ-026 On preemption, nb_preempts SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-027 A preempted M2/M3 SHALL receive no residual credit; it re-arbitrates normally.
REQ-028 SHALL ignore done bits of non-owners.
REQ-029 SHALL give simultaneous done[owner] and req[0] the normal free-arbitration path, with no preempt pulse.
REQ-030 SHALL keep per-requester wait counters for M2 and M3: increment while req high and not granted, clear on grant or when req is low, saturate at STARVE_LIM.
REQ-031 SHALL set starve_err when either wait counter reaches STARVE_LIM; the flag holds until reset.
REQ-032 SHALL accept any combination of req/done without X-propagation; illegal state encodings recover to IDLE on the next clock.

Reset
REQ-033 While reset=0, asynchronously, state SHALL be IDLE, gnt=000, owner=00, preempt=0, nb_preempts=0, starve_err=0, round-robin pointer=M2, and all hold/wait counters=0.
REQ-034 Reset asserted mid-grant SHALL drop gnt immediately, without waiting for a clock edge.
REQ-035 The first arbitration after reset deassertion SHALL occur at the first rising clk edge.

Verification
REQ-036 Scenario, contention: req=110 held from IDLE -> gnt sequence 010,010,100,100,010,010 (MAX_HOLD=2, round-robin alternation).
REQ-037 Scenario, preemption: req=010, then req=011 in the first OWN2 cycle -> next cycle gnt=001, preempt=1, nb_preempts=1.
REQ-038 Scenario, unlimited M1 hold: req=001 held 10 cycles with done=000, then done=001 with req=100 -> gnt=001 for 10 cycles, then gnt=100 on the next cycle, no IDLE cycle.
REQ-039 Scenario, starvation: M1 holds for 8 cycles while req[1]=1 (STARVE_LIM=6) -> starve_err rises on the 6th wait cycle and stays 1 after M2 is granted.
REQ-040 Scenario, reset mid-operation: reset=0 asserted mid-OWN3 -> gnt=000 and owner=00 before the next edge; after release, req=110 -> M2 granted first.
REQ-041 Scenario, counter saturation: CNT_W=2 with 5 preemptions -> nb_preempts stays at 3.
